fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one async FIFO write port among NREQ producers in the wclk domain. Each producer offers beats with a valid/ready handshake and a packet-end flag. The arbiter grants one producer at a time and forwards its beats to the FIFO's winc/wdata, stalling on wfull. A grant is held until packet end or a burst cap, so packets stay contiguous and no producer can starve the others.

---
 rtl/fifo_wr_arbiter_pkg.sv | 29 ++
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 40 ++++
 rtl/fifo_wr_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and elaboration helpers for the FIFO write-side arbiter.
package fifo_wr_arbiter_pkg;

    // Arbiter FSM: IDLE arbitrates, GRANT forwards beats of the granted producer.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Ceiling log2, used to size the grant id from the requester count.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // True when the parameter set is self-consistent: id width fits the
    // requester count and the beat counter can reach MAX_BURST-1.
    function automatic bit params_ok(input int nreq, input int idw,
                                     input int bw, input int max_burst);
        return (idw == clog2(nreq)) && ((1 << bw) > max_burst) &&
               (nreq >= 2) && (nreq <= 8) &&
               (max_burst >= 1) && (max_burst <= 255);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write-port bundle for the write-side arbiter.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [WIDTH-1:0]      wdata;
    logic [IDW-1:0]        gnt_id;
    logic                  busy;

    // Producers and the FIFO status side.
    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, winc, wdata, gnt_id, busy
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, winc, wdata, gnt_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_gnt, wrapping.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_gnt,
    output logic [IDW-1:0]  winner,
    output logic            any_req
);

    logic [IDW-1:0]  cand_id [NREQ];
    logic [NREQ-1:0] cand_hit;

    // Candidate gi is the requester at distance gi+1 from last_gnt, modulo NREQ.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum          = {1'b0, last_gnt} + (IDW+1)'(gi + 1);
            assign cand_id[gi]  = (sum >= (IDW+1)'(NREQ)) ?
                                  IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
            assign cand_hit[gi] = req[cand_id[gi]];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest active one wins.
    always_comb begin
        winner  = '0;
        any_req = |req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                winner = cand_id[i];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A grant lasts until packet end or MAX_BURST beats; one idle cycle between grants.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int MAX_BURST = 4,
    parameter int BW        = 3
) (
    input  logic              wclk,
    input  logic              wrst_n,
    fifo_wr_arbiter_if.slave  bus
);

    localparam bit PARAMS_OK = params_ok(NREQ, IDW, BW, MAX_BURST);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("fifo_wr_arbiter: inconsistent NREQ/IDW/BW/MAX_BURST");
        end
    endgenerate

    state_t          state_reg,    state_next;
    logic [IDW-1:0]  gnt_id_reg,   gnt_id_next;
    logic [BW-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [IDW-1:0]  last_gnt_reg, last_gnt_next;

    logic [IDW-1:0]  pick_id;
    logic            any_req;
    logic            accept;
    logic            rel_beat;
    logic [NREQ-1:0] ready_vec;
    logic [WIDTH-1:0] data_arr [NREQ];

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req      (bus.req_valid),
        .last_gnt (last_gnt_reg),
        .winner   (pick_id),
        .any_req  (any_req)
    );

    // Unpack the producer data bus and steer ready only to the granted producer.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign data_arr[gi]  = bus.req_data[gi*WIDTH +: WIDTH];
            assign ready_vec[gi] = accept && (gnt_id_reg == IDW'(gi));
        end
    endgenerate

    // A beat moves when the granted producer is valid and the FIFO has room;
    // the grant ends on that beat if it is the packet end or hits the cap.
    always_comb begin
        accept   = (state_reg == ST_GRANT) && bus.req_valid[gnt_id_reg] && !bus.wfull;
        rel_beat = accept && (bus.req_last[gnt_id_reg] ||
                              (beat_cnt_reg == BW'(MAX_BURST - 1)));
    end

    // Zero-latency datapath into the FIFO write port.
    assign bus.winc      = accept;
    assign bus.wdata     = (state_reg == ST_GRANT) ? data_arr[gnt_id_reg] : '0;
    assign bus.req_ready = ready_vec;
    assign bus.gnt_id    = gnt_id_reg;
    assign bus.busy      = (state_reg == ST_GRANT);

    // State register; reset abandons any partial packet immediately.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_reg    <= ST_IDLE;
            gnt_id_reg   <= '0;
            beat_cnt_reg <= '0;
            last_gnt_reg <= IDW'(NREQ - 1);
        end else begin
            state_reg    <= state_next;
            gnt_id_reg   <= gnt_id_next;
            beat_cnt_reg <= beat_cnt_next;
            last_gnt_reg <= last_gnt_next;
        end
    end

    // Next-state: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        state_next    = state_reg;
        gnt_id_next   = gnt_id_reg;
        beat_cnt_next = beat_cnt_reg;
        last_gnt_next = last_gnt_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_id_next   = pick_id;
                    beat_cnt_next = '0;
                    state_next    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    beat_cnt_next = beat_cnt_reg + BW'(1);
                end
                if (rel_beat) begin
                    beat_cnt_next = '0;
                    last_gnt_next = gnt_id_reg;
                    state_next    = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: cycle-vector table plus
// scoreboarded multi-cycle scenarios (round-robin, burst cap, backpressure, reset).
`timescale 1ns/100ps
module tb_fifo_wr_arbiter;

    localparam int WIDTH     = 8;
    localparam int NREQ      = 4;
    localparam int IDW       = 2;
    localparam int MAX_BURST = 4;
    localparam int BW        = 3;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

    fifo_wr_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .MAX_BURST(MAX_BURST), .BW(BW)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        wfull;
        logic        exp_winc;
        logic        exp_busy;
        logic [1:0]  exp_gnt;
        logic [7:0]  exp_wdata;
        logic [3:0]  exp_ready;
    } vec_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_winc_cyc = -1;
    int   wr_cnt   = 0;
    bit   chk_gap  = 1'b0;
    logic wfull_drive = 1'b0;

    logic [8:0] src_mem [NREQ][32];
    int         src_head [NREQ];
    int         src_tail [NREQ];
    exp_t       exp_q [$];
    vec_t       vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_beat(input int id, input logic [7:0] d, input logic last);
        src_mem[id][src_tail[id]] = {last, d};
        src_tail[id]++;
    endtask

    task automatic push_exp(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = 2'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic bit src_pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < NREQ; i++) if (src_head[i] < src_tail[i]) p = 1'b1;
        return p;
    endfunction

    task automatic flush();
        for (int i = 0; i < NREQ; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        exp_q.delete();
        last_winc_cyc = -1;
        wr_cnt = 0;
    endtask

    // 1 ns reset pulse between clock edges; outputs must be idle during it.
    task automatic reset_pulse();
        @(negedge wclk);
        #2 wrst_n = 1'b0;
        #0.5;
        check("pulse_winc",   bus.winc,   1'b0);
        check("pulse_busy",   bus.busy,   1'b0);
        check("pulse_gnt_id", bus.gnt_id, 2'd0);
        #0.5 wrst_n = 1'b1;
        flush();
    endtask

    // One clock: drive source heads, sample outputs, score any FIFO write.
    task automatic run_cycle();
        logic [NREQ-1:0]       v;
        logic [NREQ-1:0]       l;
        logic [NREQ*WIDTH-1:0] d;
        logic [NREQ-1:0]       oh;
        exp_t                  e;
        v = '0;
        l = '0;
        d = '0;
        @(negedge wclk);
        for (int i = 0; i < NREQ; i++) begin
            if (src_head[i] < src_tail[i]) begin
                v[i] = 1'b1;
                l[i] = src_mem[i][src_head[i]][8];
                d[i*WIDTH +: WIDTH] = src_mem[i][src_head[i]][7:0];
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.wfull     = wfull_drive;
        #1;
        cyc++;
        if (bus.winc === 1'b1) begin
            $display("cycle %0d write gnt_id=%0d data=0x%02h", cyc, bus.gnt_id, bus.wdata);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got id %0d data 0x%02h, required no write",
                         bus.gnt_id, bus.wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_id",   bus.gnt_id, e.id);
                check("write_data", bus.wdata,  e.data);
            end
            oh = '0;
            oh[bus.gnt_id] = 1'b1;
            check("ready_onehot", bus.req_ready, oh);
            if (chk_gap && last_winc_cyc >= 0) check("grant_gap", cyc - last_winc_cyc, 2);
            last_winc_cyc = cyc;
            wr_cnt++;
        end else begin
            check("ready_no_write", bus.req_ready, 4'b0000);
        end
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i] === 1'b1) src_head[i]++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_pending()) && n < budget) begin
            run_cycle();
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
        end
        run_cycle();
        run_cycle();
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n;
        n = 0;
        while (wr_cnt < target && n < budget) begin
            run_cycle();
            n++;
        end
        if (wr_cnt < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_timeout: got %0d writes, required %0d", wr_cnt, target);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.wfull     = 1'b0;
        flush();

        // Reset with every producer valid: nothing moves, then requester 0 goes first.
        for (int i = 0; i < NREQ; i++) begin
            push_beat(i, 8'h90 + 8'(i), 1'b1);
            push_exp(i, 8'h90 + 8'(i));
        end
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            check("rst_winc",   bus.winc,   1'b0);
            check("rst_busy",   bus.busy,   1'b0);
            check("rst_gnt_id", bus.gnt_id, 2'd0);
            check("rst_wdata",  bus.wdata,  8'h00);
        end
        wrst_n  = 1'b1;
        chk_gap = 1'b1;
        drain(50);

        // Cycle-vector table: single packet from req 2, gating, full stall, valid drop.
        vecs[0] = '{4'b0100, 4'b0000, 32'h004D0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000};
        vecs[1] = '{4'b0100, 4'b0000, 32'h004D0000, 1'b0, 1'b1, 1'b1, 2'd2, 8'h4D, 4'b0100};
        vecs[2] = '{4'b0100, 4'b0000, 32'h004F0000, 1'b0, 1'b1, 1'b1, 2'd2, 8'h4F, 4'b0100};
        vecs[3] = '{4'b0100, 4'b0100, 32'h00480000, 1'b0, 1'b1, 1'b1, 2'd2, 8'h48, 4'b0100};
        vecs[4] = '{4'b0000, 4'b0000, 32'h00AA0000, 1'b0, 1'b0, 1'b0, 2'd2, 8'h00, 4'b0000};
        vecs[5] = '{4'b0001, 4'b0000, 32'h00000011, 1'b1, 1'b0, 1'b0, 2'd2, 8'h00, 4'b0000};
        vecs[6] = '{4'b0001, 4'b0000, 32'h00000011, 1'b1, 1'b0, 1'b1, 2'd0, 8'h11, 4'b0000};
        vecs[7] = '{4'b0000, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 4'b0000};
        vecs[8] = '{4'b0001, 4'b0001, 32'h00000011, 1'b0, 1'b1, 1'b1, 2'd0, 8'h11, 4'b0001};
        vecs[9] = '{4'b0000, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000};
        chk_gap = 1'b0;
        reset_pulse();
        for (int r = 0; r < 10; r++) begin
            @(negedge wclk);
            bus.req_valid = vecs[r].valid;
            bus.req_last  = vecs[r].last;
            bus.req_data  = vecs[r].data;
            bus.wfull     = vecs[r].wfull;
            #1;
            $display("vector %0d winc=%0b busy=%0b gnt_id=%0d wdata=0x%02h ready=%b",
                     r, bus.winc, bus.busy, bus.gnt_id, bus.wdata, bus.req_ready);
            check($sformatf("vec%0d_winc", r),  bus.winc,      vecs[r].exp_winc);
            check($sformatf("vec%0d_busy", r),  bus.busy,      vecs[r].exp_busy);
            check($sformatf("vec%0d_gnt", r),   bus.gnt_id,    vecs[r].exp_gnt);
            check($sformatf("vec%0d_wdata", r), bus.wdata,     vecs[r].exp_wdata);
            check($sformatf("vec%0d_ready", r), bus.req_ready, vecs[r].exp_ready);
        end

        // Round-robin: three 1-beat packets per requester, order 0,1,2,3 repeating.
        reset_pulse();
        chk_gap = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                push_beat(i, 8'(16 * i + k), 1'b1);
                push_exp(i, 8'(16 * i + k));
            end
        end
        drain(100);

        // Burst cap: req 1 has 8 beats, req 3 has 2; req 1 is cut after 4.
        reset_pulse();
        chk_gap = 1'b0;
        for (int k = 0; k < 8; k++) push_beat(1, 8'hA0 + 8'(k), (k == 7));
        push_beat(3, 8'hC0, 1'b0);
        push_beat(3, 8'hC1, 1'b1);
        for (int k = 0; k < 4; k++) push_exp(1, 8'hA0 + 8'(k));
        push_exp(3, 8'hC0);
        push_exp(3, 8'hC1);
        for (int k = 4; k < 8; k++) push_exp(1, 8'hA0 + 8'(k));
        drain(100);

        // Backpressure: wfull for 5 cycles after beat 2; cap must still land after 4 beats.
        reset_pulse();
        for (int k = 0; k < 6; k++) push_beat(0, 8'h30 + 8'(k), (k == 5));
        push_beat(2, 8'h50, 1'b1);
        for (int k = 0; k < 4; k++) push_exp(0, 8'h30 + 8'(k));
        push_exp(2, 8'h50);
        push_exp(0, 8'h34);
        push_exp(0, 8'h35);
        wait_writes(2, 20);
        wfull_drive = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_cycle();
            check("full_winc", bus.winc, 1'b0);
            check("full_busy", bus.busy, 1'b1);
        end
        wfull_drive = 1'b0;
        drain(100);

        // Reset mid-burst: abandon req 0's packet, then requester 0 must win first again.
        reset_pulse();
        push_beat(2, 8'h70, 1'b1);
        push_exp(2, 8'h70);
        drain(50);
        for (int k = 0; k < 4; k++) push_beat(0, 8'h60 + 8'(k), (k == 3));
        push_exp(0, 8'h60);
        push_exp(0, 8'h61);
        wr_cnt = 0;
        wait_writes(2, 20);
        @(posedge wclk);
        #2 wrst_n = 1'b0;
        #1;
        check("midrst_winc",   bus.winc,      1'b0);
        check("midrst_busy",   bus.busy,      1'b0);
        check("midrst_gnt_id", bus.gnt_id,    2'd0);
        check("midrst_ready",  bus.req_ready, 4'b0000);
        for (int k = 0; k < 2; k++) begin
            run_cycle();
            check("midrst_hold_winc", bus.winc, 1'b0);
        end
        flush();
        wrst_n = 1'b1;
        chk_gap = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            push_beat(i, 8'h80 + 8'(i), 1'b1);
            push_exp(i, 8'h80 + 8'(i));
        end
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
